// File: rtl/adam_mem_arb_pkg.sv
// Shared ADAM memory-arbiter configuration: interface widths, the arbiter state type,
// and a helper for round-robin index widths.
package adam_mem_arb_pkg;

   localparam int unsigned ADAM_ADDR_WIDTH = 32;
   localparam int unsigned ADAM_DATA_WIDTH = 32;
   localparam int unsigned ADAM_STRB_WIDTH = ADAM_DATA_WIDTH / 8;

   typedef logic [ADAM_ADDR_WIDTH-1:0] ADDR_T;
   typedef logic [ADAM_DATA_WIDTH-1:0] DATA_T;
   typedef logic [ADAM_STRB_WIDTH-1:0] STRB_T;

   typedef enum logic [1:0] {
      MEM_ARB_PAUSED = 2'd0,
      MEM_ARB_RUN    = 2'd1,
      MEM_ARB_DRAIN  = 2'd2
   } MEM_ARB_STATE_T;

   // Port-index width; a single port still needs one bit to carry a constant zero.
   function automatic int unsigned rr_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adam_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr,
// wrapping from the last port back to port 0.
module adam_rr_pick
   import adam_mem_arb_pkg::*;
#(
   parameter int unsigned NO_PORTS = 2,
   localparam int unsigned IDX_W   = rr_idx_width(NO_PORTS)
) (
   input  logic [NO_PORTS-1:0] req,
   input  logic [IDX_W-1:0]    ptr,
   output logic [NO_PORTS-1:0] gnt_c,
   output logic [IDX_W-1:0]    idx_c,
   output logic                any_c
);

   always_comb begin
      int unsigned      pos;
      logic [IDX_W-1:0] sel;
      gnt_c = '0;
      idx_c = '0;
      any_c = 1'b0;
      pos   = 0;
      sel   = '0;
      for (int unsigned off = 0; off < NO_PORTS; off++) begin
         pos = 32'(ptr) + off;
         if (pos >= NO_PORTS) begin
            pos = pos - NO_PORTS;
         end
         sel = IDX_W'(pos);
         if (!any_c && req[sel]) begin
            any_c      = 1'b1;
            gnt_c[sel] = 1'b1;
            idx_c      = sel;
         end
      end
   end

endmodule

// File: rtl/adam_mem_arb.sv
// Round-robin arbiter sharing one adam_mem among NO_PORTS requesters, with a
// pause/drain handshake and a one-cycle registered read-return path.
module adam_mem_arb
   import adam_mem_arb_pkg::*;
#(
   parameter int unsigned NO_PORTS   = 2,
   parameter int unsigned ADDR_WIDTH = ADAM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = ADAM_DATA_WIDTH,
   parameter int unsigned STRB_WIDTH = ADAM_STRB_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  pause_req,
   output logic                  pause_ack,

   input  logic [NO_PORTS-1:0]   req,
   output logic [NO_PORTS-1:0]   gnt,
   input  logic [ADDR_WIDTH-1:0] addr  [NO_PORTS],
   input  logic [NO_PORTS-1:0]   we,
   input  logic [STRB_WIDTH-1:0] be    [NO_PORTS],
   input  logic [DATA_WIDTH-1:0] wdata [NO_PORTS],
   output logic [NO_PORTS-1:0]   rvalid,
   output logic [DATA_WIDTH-1:0] rdata [NO_PORTS],

   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [STRB_WIDTH-1:0] mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned IDX_W = rr_idx_width(NO_PORTS);

   MEM_ARB_STATE_T      state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                rd_pend_q, rd_pend_d;
   logic [NO_PORTS-1:0] rvalid_q, rvalid_d;
   logic                pause_ack_q, pause_ack_d;

   logic [NO_PORTS-1:0] pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic                grant_en;

   adam_rr_pick #(
      .NO_PORTS (NO_PORTS)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .gnt_c (pick_gnt),
      .idx_c (pick_idx),
      .any_c (pick_any)
   );

   // Next state, grant qualification, memory mux and read-return bookkeeping.
   always_comb begin
      state_d     = state_q;
      grant_en    = 1'b0;
      rr_ptr_d    = rr_ptr_q;

      case (state_q)
         MEM_ARB_PAUSED: begin
            if (!pause_req) begin
               state_d = MEM_ARB_RUN;
            end
         end
         MEM_ARB_RUN: begin
            // A pause request suppresses the grant in the very cycle it is seen.
            if (pause_req) begin
               state_d = MEM_ARB_DRAIN;
            end else begin
               grant_en = 1'b1;
            end
         end
         MEM_ARB_DRAIN: begin
            if (!rd_pend_q) begin
               state_d = MEM_ARB_PAUSED;
            end
         end
         default: begin
            state_d = MEM_ARB_PAUSED;
         end
      endcase

      if (rst) begin
         grant_en = 1'b0;
      end

      gnt       = grant_en ? pick_gnt : '0;
      mem_req   = grant_en & pick_any;
      mem_addr  = addr[pick_idx];
      mem_we    = we[pick_idx];
      mem_be    = be[pick_idx];
      mem_wdata = wdata[pick_idx];

      if (mem_req) begin
         rr_ptr_d = (32'(pick_idx) == NO_PORTS - 1) ? '0 : IDX_W'(32'(pick_idx) + 1);
      end

      rd_pend_d   = mem_req & ~mem_we;
      rvalid_d    = rd_pend_d ? gnt : '0;
      pause_ack_d = (state_d == MEM_ARB_PAUSED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= MEM_ARB_PAUSED;
         rr_ptr_q    <= '0;
         rd_pend_q   <= 1'b0;
         rvalid_q    <= '0;
         pause_ack_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         rd_pend_q   <= rd_pend_d;
         rvalid_q    <= rvalid_d;
         pause_ack_q <= pause_ack_d;
      end
   end

   // Reset masks a read return that was already registered when reset arrived.
   assign rvalid    = rst ? '0 : rvalid_q;
   assign pause_ack = pause_ack_q | rst;

   always_comb begin
      for (int i = 0; i < NO_PORTS; i++) begin
         rdata[i] = mem_rdata;
      end
   end

endmodule

// File: tb/tb_adam_mem_arb.sv
// Bench for adam_mem_arb: two ports on a 1024-word memory, directed scenarios plus
// randomized traffic checked against a cycle-level reference model.
module tb_adam_mem_arb;

   localparam int NP       = 2;
   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int SW       = 4;
   localparam int MEM_SIZE = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          pause_req;
   logic          pause_ack;
   logic [NP-1:0] req;
   logic [NP-1:0] gnt;
   logic [AW-1:0] addr  [NP];
   logic [NP-1:0] we;
   logic [SW-1:0] be    [NP];
   logic [DW-1:0] wdata [NP];
   logic [NP-1:0] rvalid;
   logic [DW-1:0] rdata [NP];
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [SW-1:0] mem_be;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   adam_mem_arb #(
      .NO_PORTS   (NP),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .STRB_WIDTH (SW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pause_req (pause_req),
      .pause_ack (pause_ack),
      .req       (req),
      .gnt       (gnt),
      .addr      (addr),
      .we        (we),
      .be        (be),
      .wdata     (wdata),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // adam_mem stand-in: word addressed, byte strobes, read data one cycle after the request.
   logic [DW-1:0] env_mem [MEM_SIZE];
   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < SW; b++) begin
               if (mem_be[b]) env_mem[mem_addr[9:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
         end else begin
            mem_rdata <= env_mem[mem_addr[9:0]];
         end
      end
   end

   // Reference model: paused/draining flags, rotating priority, expected read return.
   logic [DW-1:0] ref_mem [MEM_SIZE];
   bit            m_paused   = 1'b1;
   bit            m_draining = 1'b0;
   int            m_ptr      = 0;
   int            m_rv_port  = -1;
   logic [DW-1:0] m_rv_data  = '0;

   function automatic int exp_grant();
      if (rst || m_paused || m_draining || pause_req) return -1;
      for (int k = 0; k < NP; k++) begin
         if (req[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
      end
      return -1;
   endfunction

   function automatic logic [NP-1:0] onehot(input int p);
      if (p < 0) return '0;
      return NP'(1) << p;
   endfunction

   always @(posedge clk) begin
      int g;
      if (rst) begin
         m_paused   = 1'b1;
         m_draining = 1'b0;
         m_ptr      = 0;
         m_rv_port  = -1;
      end else begin
         g         = exp_grant();
         m_rv_port = -1;
         if (g >= 0) begin
            if (we[g]) begin
               for (int b = 0; b < SW; b++) begin
                  if (be[g][b]) ref_mem[addr[g][9:0]][b*8 +: 8] = wdata[g][b*8 +: 8];
               end
            end else begin
               m_rv_port = g;
               m_rv_data = ref_mem[addr[g][9:0]];
            end
            m_ptr = (g + 1) % NP;
         end
         if (m_paused) begin
            m_paused = pause_req;
         end else if (m_draining) begin
            m_draining = 1'b0;
            m_paused   = 1'b1;
         end else if (pause_req) begin
            m_draining = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      pause_req = 1'b0;
      req       = '1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total += 4;
         if (gnt !== '0)      begin bad++; $display("FAIL reset_gnt c%0d: got %b want 00", c, gnt); end
         if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req c%0d: got %b want 0", c, mem_req); end
         if (rvalid !== '0)   begin bad++; $display("FAIL reset_rvalid c%0d: got %b want 00", c, rvalid); end
         if (pause_ack !== 1'b1) begin bad++; $display("FAIL reset_ack c%0d: got %b want 1", c, pause_ack); end
         tick();
      end
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      total += 2;
      if (pause_ack !== 1'b1) begin bad++; $display("FAIL post_reset_ack: got %b want 1", pause_ack); end
      if (gnt !== '0)         begin bad++; $display("FAIL post_reset_gnt: got %b want 00", gnt); end
      tick();
      @(negedge clk);
      total += 2;
      if (pause_ack !== 1'b0) begin bad++; $display("FAIL resume_ack: got %b want 0", pause_ack); end
      if (pause_ack !== m_paused) begin bad++; $display("FAIL resume_ack_model: got %b want %b", pause_ack, m_paused); end
      tick();
   endtask

   task automatic test_write_read();
      req = 2'b01; we = 2'b01; addr[0] = 32'h10; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      total += 4;
      if (gnt !== 2'b01)        begin bad++; $display("FAIL wr_gnt: got %b want 01", gnt); end
      if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL wr_mem_req_we: got %b%b want 11", mem_req, mem_we); end
      if (mem_addr !== 32'h10)  begin bad++; $display("FAIL wr_addr: got %h want 00000010", mem_addr); end
      if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata); end
      tick();
      we = 2'b00;
      @(negedge clk);
      total += 2;
      if (gnt !== 2'b01)  begin bad++; $display("FAIL rd_gnt: got %b want 01", gnt); end
      if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_we: got %b want 0", mem_we); end
      tick();
      req = '0;
      @(negedge clk);
      total += 2;
      if (rvalid !== 2'b01) begin bad++; $display("FAIL rd_rvalid: got %b want 01", rvalid); end
      if (rdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata: got %h want deadbeef", rdata[0]); end
      tick();
   endtask

   task automatic test_alternate();
      int       g;
      int       grants;
      logic [NP-1:0] prev;
      grants = 0;
      prev   = '0;
      for (int c = 0; c < 8; c++) begin
         req = 2'b11; we = 2'b00;
         addr[0] = AW'($urandom_range(0, 63));
         addr[1] = AW'($urandom_range(0, 63));
         @(negedge clk);
         g = exp_grant();
         total += 3;
         if (gnt !== onehot(g)) begin bad++; $display("FAIL alt_gnt c%0d: got %b want %b", c, gnt, onehot(g)); end
         if (mem_req !== 1'b1)  begin bad++; $display("FAIL alt_mem_req c%0d: got %b want 1", c, mem_req); end
         if (rvalid !== onehot(m_rv_port)) begin bad++; $display("FAIL alt_rvalid c%0d: got %b want %b", c, rvalid, onehot(m_rv_port)); end
         if (m_rv_port >= 0) begin
            total++;
            if (rdata[m_rv_port] !== m_rv_data) begin bad++; $display("FAIL alt_rdata c%0d: got %h want %h", c, rdata[m_rv_port], m_rv_data); end
         end
         if (c > 0) begin
            total++;
            if (gnt === prev) begin bad++; $display("FAIL alt_alternate c%0d: got %b want not %b", c, gnt, prev); end
         end
         if (gnt != '0) grants++;
         prev = gnt;
         tick();
      end
      req = '0;
      @(negedge clk);
      total += 2;
      if (grants !== 8) begin bad++; $display("FAIL alt_count: got %0d want 8", grants); end
      if (rvalid !== onehot(m_rv_port)) begin bad++; $display("FAIL alt_last_rvalid: got %b want %b", rvalid, onehot(m_rv_port)); end
      tick();
   endtask

   task automatic test_pause();
      logic [DW-1:0] exp_rd;
      req = 2'b10; we = 2'b00; addr[1] = 32'h20; pause_req = 1'b0;
      exp_rd = ref_mem[10'h20];
      @(negedge clk);
      total++;
      if (gnt !== 2'b10) begin bad++; $display("FAIL pause_rd_gnt: got %b want 10", gnt); end
      tick();
      req = 2'b01; addr[0] = 32'h10; pause_req = 1'b1;
      @(negedge clk);
      total += 4;
      if (gnt !== '0)       begin bad++; $display("FAIL pause_trans_gnt: got %b want 00", gnt); end
      if (rvalid !== 2'b10) begin bad++; $display("FAIL pause_rvalid: got %b want 10", rvalid); end
      if (rdata[1] !== exp_rd) begin bad++; $display("FAIL pause_rdata: got %h want %h", rdata[1], exp_rd); end
      if (pause_ack !== 1'b0) begin bad++; $display("FAIL pause_trans_ack: got %b want 0", pause_ack); end
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total += 3;
         if (pause_ack !== m_paused) begin bad++; $display("FAIL pause_ack c%0d: got %b want %b", c, pause_ack, m_paused); end
         if (gnt !== '0)        begin bad++; $display("FAIL paused_gnt c%0d: got %b want 00", c, gnt); end
         if (mem_req !== 1'b0)  begin bad++; $display("FAIL paused_mem_req c%0d: got %b want 0", c, mem_req); end
         tick();
      end
      total++;
      if (pause_ack !== 1'b1) begin bad++; $display("FAIL paused_ack_final: got %b want 1", pause_ack); end
      pause_req = 1'b0;
      @(negedge clk);
      total += 2;
      if (gnt !== '0)        begin bad++; $display("FAIL unpause_gnt: got %b want 00", gnt); end
      if (pause_ack !== 1'b1) begin bad++; $display("FAIL unpause_ack: got %b want 1", pause_ack); end
      tick();
      @(negedge clk);
      total += 2;
      if (gnt !== 2'b01)     begin bad++; $display("FAIL resume_gnt: got %b want 01", gnt); end
      if (pause_ack !== 1'b0) begin bad++; $display("FAIL resume_ack2: got %b want 0", pause_ack); end
      tick();
      req = '0;
      @(negedge clk);
      total += 2;
      if (rvalid !== 2'b01) begin bad++; $display("FAIL resume_rvalid: got %b want 01", rvalid); end
      if (rdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL resume_rdata: got %h want deadbeef", rdata[0]); end
      tick();
   endtask

   task automatic test_strobe();
      req = 2'b10; we = 2'b10; addr[1] = 32'h30; be[1] = 4'hF; wdata[1] = 32'hFFFF_FFFF;
      @(negedge clk);
      total++;
      if (gnt !== 2'b10) begin bad++; $display("FAIL strb_fill_gnt: got %b want 10", gnt); end
      tick();
      be[1] = 4'b0011; wdata[1] = 32'h0000_1234;
      @(negedge clk);
      total += 2;
      if (gnt !== 2'b10)     begin bad++; $display("FAIL strb_part_gnt: got %b want 10", gnt); end
      if (mem_be !== 4'b0011) begin bad++; $display("FAIL strb_be: got %b want 0011", mem_be); end
      tick();
      we = 2'b00;
      @(negedge clk);
      total++;
      if (gnt !== 2'b10) begin bad++; $display("FAIL strb_rd_gnt: got %b want 10", gnt); end
      tick();
      req = '0;
      @(negedge clk);
      total += 3;
      if (rvalid !== 2'b10) begin bad++; $display("FAIL strb_rvalid: got %b want 10", rvalid); end
      if (rdata[1] !== 32'hFFFF_1234) begin bad++; $display("FAIL strb_rdata: got %h want ffff1234", rdata[1]); end
      if (rdata[1] !== m_rv_data) begin bad++; $display("FAIL strb_rdata_model: got %h want %h", rdata[1], m_rv_data); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      req = 2'b01; we = 2'b00; addr[0] = 32'h30;
      @(negedge clk);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL rmr_gnt: got %b want 01", gnt); end
      tick();
      rst = 1'b1; req = '0;
      @(negedge clk);
      total += 2;
      if (rvalid !== '0)     begin bad++; $display("FAIL rmr_rvalid_in_reset: got %b want 00", rvalid); end
      if (pause_ack !== 1'b1) begin bad++; $display("FAIL rmr_ack_in_reset: got %b want 1", pause_ack); end
      tick();
      rst = 1'b0;
      @(negedge clk);
      total += 3;
      if (rvalid !== '0)     begin bad++; $display("FAIL rmr_rvalid_after: got %b want 00", rvalid); end
      if (gnt !== '0)        begin bad++; $display("FAIL rmr_gnt_after: got %b want 00", gnt); end
      if (pause_ack !== 1'b1) begin bad++; $display("FAIL rmr_ack_after: got %b want 1", pause_ack); end
      tick();
      req = 2'b11; we = 2'b00; addr[1] = 32'h20;
      @(negedge clk);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL rmr_priority: got %b want 01", gnt); end
      tick();
      req = '0;
      @(negedge clk);
      total += 2;
      if (rvalid !== 2'b01) begin bad++; $display("FAIL rmr_rvalid_resume: got %b want 01", rvalid); end
      if (rdata[0] !== 32'hFFFF_1234) begin bad++; $display("FAIL rmr_rdata: got %h want ffff1234", rdata[0]); end
      tick();
   endtask

   task automatic test_random();
      int            g;
      int            wcnt [NP];
      logic [NP-1:0] last_gnt;
      last_gnt = '0;
      for (int p = 0; p < NP; p++) wcnt[p] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (last_gnt[p]) req[p] = 1'b0;
            if (!req[p] && $urandom_range(0, 2) != 0) begin
               req[p]   = 1'b1;
               we[p]    = 1'($urandom_range(0, 1));
               addr[p]  = AW'($urandom_range(0, 63));
               be[p]    = SW'($urandom);
               wdata[p] = $urandom;
            end
         end
         if ($urandom_range(0, 29) == 0) pause_req = ~pause_req;
         @(negedge clk);
         g = exp_grant();
         total += 4;
         if (gnt !== onehot(g)) begin bad++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, onehot(g)); end
         if (mem_req !== (g >= 0)) begin bad++; $display("FAIL rnd_mem_req c%0d: got %b want %b", c, mem_req, g >= 0); end
         if (pause_ack !== m_paused) begin bad++; $display("FAIL rnd_ack c%0d: got %b want %b", c, pause_ack, m_paused); end
         if (rvalid !== onehot(m_rv_port)) begin bad++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, onehot(m_rv_port)); end
         if (m_rv_port >= 0) begin
            total++;
            if (rdata[m_rv_port] !== m_rv_data) begin bad++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata[m_rv_port], m_rv_data); end
         end
         if (g >= 0) begin
            total += 2;
            if (mem_addr !== addr[g]) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, addr[g]); end
            if (mem_we !== we[g])     begin bad++; $display("FAIL rnd_we c%0d: got %b want %b", c, mem_we, we[g]); end
            if (we[g]) begin
               total += 2;
               if (mem_be !== be[g])       begin bad++; $display("FAIL rnd_be c%0d: got %b want %b", c, mem_be, be[g]); end
               if (mem_wdata !== wdata[g]) begin bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, wdata[g]); end
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (g == p) wcnt[p] = 0;
            else if (g >= 0 && req[p]) wcnt[p]++;
            total++;
            if (wcnt[p] > NP - 1) begin bad++; $display("FAIL rnd_fair c%0d p%0d: got %0d waits want <=%0d", c, p, wcnt[p], NP - 1); end
         end
         last_gnt = gnt;
         tick();
      end
      pause_req = 1'b0;
      req       = '0;
      repeat (4) tick();
   endtask

   initial begin
      for (int i = 0; i < MEM_SIZE; i++) begin
         env_mem[i] = '0;
         ref_mem[i] = '0;
      end
      rst = 1'b1; pause_req = 1'b0; req = '0; we = '0;
      for (int p = 0; p < NP; p++) begin
         addr[p] = '0; be[p] = '0; wdata[p] = '0;
      end
      test_reset();
      test_write_read();
      test_alternate();
      test_pause();
      test_strobe();
      test_reset_mid_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
